// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the riscv_core memory responder.
// Holds the controller state enum, the fetch NOP and the fault cause codes.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } mem_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_IFETCH    = 2'd1;
  localparam logic [1:0] FAULT_DMISALIGN = 2'd2;
  localparam logic [1:0] FAULT_DRANGE    = 2'd3;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Core-side and loader-side signals of the memory responder.
// fault/fault_code exist only when MEM_FAULT_EN is defined.
interface riscv_mem_responder_if #(
  parameter int XLEN = 32
);
  logic            core_rst;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] ir_data;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] dw_data;
  logic            d_we;
  logic [XLEN-1:0] dr_data;
  // Load port: a word moves on every edge where ld_valid && ld_ready are both
  // high; ld_ready does not depend on ld_valid, and ld_valid may idle freely.
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;
  logic            ld_ready;
`ifdef MEM_FAULT_EN
  logic            fault;
  logic [1:0]      fault_code;
`endif

  modport slave (
`ifdef MEM_FAULT_EN
    output fault, fault_code,
`endif
    output core_rst, ir_data, dr_data, ld_ready,
    input  i_addr, d_addr, dw_data, d_we, ld_valid, ld_data, ld_last
  );

  modport master (
`ifdef MEM_FAULT_EN
    input  fault, fault_code,
`endif
    input  core_rst, ir_data, dr_data, ld_ready,
    output i_addr, d_addr, dw_data, d_we, ld_valid, ld_data, ld_last
  );
endinterface

// File: rtl/riscv_word_ram.sv
// Word array with asynchronous read and synchronous write.
// A read of the word being written returns the old contents.
module riscv_word_ram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_mem_responder.sv
// Instruction/data memory for riscv_core: zero-fills dmem, loads the program, then runs.
// Optional fault detection is enabled with the MEM_FAULT_EN macro.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_responder_if.slave  mem_io,
  output mem_state_e            state_o
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [IAW-1:0] PTR_LAST = IAW'(IMEM_DEPTH - 1);
  localparam logic [DAW-1:0] CNT_LAST = DAW'(DMEM_DEPTH - 1);

  mem_state_e     state_q;
  logic [DAW-1:0] cnt_q;
  logic [IAW-1:0] ptr_q;
  logic           core_rst_q;

  logic [IAW-1:0]  i_idx;
  logic [DAW-1:0]  d_idx;
  logic            i_in_range, d_in_range, store_ok;
  logic            imem_we, dmem_we;
  logic [DAW-1:0]  dmem_waddr;
  logic [XLEN-1:0] dmem_wdata, imem_rdata, dmem_rdata;

  assign i_idx      = mem_io.i_addr[IAW+1:2];
  assign d_idx      = mem_io.d_addr[DAW+1:2];
  assign i_in_range = (mem_io.i_addr[XLEN-1:IAW+2] == '0);
  assign d_in_range = (mem_io.d_addr[XLEN-1:DAW+2] == '0);

  assign imem_we = !rst && (state_q == LOAD) && mem_io.ld_valid;

  // CLEAR owns the dmem write port; the core only gets it in RUN.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_waddr = d_idx;
    dmem_wdata = mem_io.dw_data;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          dmem_we    = 1'b1;
          dmem_waddr = cnt_q;
          dmem_wdata = '0;
        end
        RUN:     dmem_we = mem_io.d_we && d_in_range && store_ok;
        default: dmem_we = 1'b0;
      endcase
    end
  end

  riscv_word_ram #(.WIDTH(XLEN), .DEPTH(IMEM_DEPTH)) u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (ptr_q),
    .wdata_i (mem_io.ld_data),
    .raddr_i (i_idx),
    .rdata_o (imem_rdata)
  );

  riscv_word_ram #(.WIDTH(XLEN), .DEPTH(DMEM_DEPTH)) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .waddr_i (dmem_waddr),
    .wdata_i (dmem_wdata),
    .raddr_i (d_idx),
    .rdata_o (dmem_rdata)
  );

  // core_rst drops on the same edge that enters RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ptr_q      <= '0;
      core_rst_q <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= LOAD;
        end
        LOAD: begin
          if (mem_io.ld_valid) begin
            ptr_q <= ptr_q + 1'b1;
            if (mem_io.ld_last || (ptr_q == PTR_LAST)) begin
              state_q    <= RUN;
              core_rst_q <= 1'b0;
            end
          end
        end
        RUN:     core_rst_q <= 1'b0;
        default: begin
          state_q    <= CLEAR;
          core_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_io.core_rst = core_rst_q;
  assign mem_io.ld_ready = (state_q == LOAD);
  assign mem_io.ir_data  = ((state_q == RUN) && i_in_range) ? imem_rdata : XLEN'(NOP_INSN);
  assign mem_io.dr_data  = d_in_range ? dmem_rdata : '0;
  assign state_o         = state_q;

`ifdef MEM_FAULT_EN
  logic       fault_q;
  logic [1:0] fault_code_q, cause_d;

  // Priority: fetch cause over misaligned store over out-of-range store.
  always_comb begin
    cause_d = FAULT_NONE;
    if ((mem_io.i_addr[1:0] != 2'b00) || !i_in_range)            cause_d = FAULT_IFETCH;
    else if (mem_io.d_we && (mem_io.d_addr[1:0] != 2'b00))       cause_d = FAULT_DMISALIGN;
    else if (mem_io.d_we && !d_in_range)                         cause_d = FAULT_DRANGE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else if ((state_q == RUN) && !fault_q && (cause_d != FAULT_NONE)) begin
      fault_q      <= 1'b1;
      fault_code_q <= cause_d;
    end
  end

  assign store_ok          = (mem_io.d_addr[1:0] == 2'b00);
  assign mem_io.fault      = fault_q;
  assign mem_io.fault_code = fault_code_q;
`else
  logic unused_byte_bits;
  assign unused_byte_bits = ^{mem_io.i_addr[1:0], mem_io.d_addr[1:0]};
  assign store_ok         = 1'b1;
`endif

endmodule

// File: doc/riscv_mem_responder.md
# riscv_mem_responder

Memory-side responder for `riscv_core`: services its instruction-fetch port (`i_addr`/`ir_data`) and data port (`d_addr`/`dw_data`/`d_we`/`dr_data`) from on-chip instruction and data word arrays. After reset it zero-fills data memory, then accepts a program image over a valid/ready load port. It holds the core in reset until both steps finish. It sits between the core and the bench/SoC top and replaces ad-hoc bench memories.

## Interface
- `XLEN`, default 32: data and address width.
- `IMEM_DEPTH`, default 32: instruction words, power of two.
- `DMEM_DEPTH`, default 32: data words, power of two.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `core_rst` output, 1 bit: reset to `riscv_core`; registered.
- `i_addr` input, XLEN bits: core fetch byte address.
- `ir_data` output, XLEN bits: fetched instruction.
- `d_addr` input, XLEN bits: core data byte address.
- `dw_data` input, XLEN bits: store data.
- `d_we` input, 1 bit: store enable.
- `dr_data` output, XLEN bits: load data.
- `ld_valid` input, 1 bit: load word valid.
- `ld_data` input, XLEN bits: program word.
- `ld_last` input, 1 bit: final program word.
- `ld_ready` output, 1 bit: load word accepted.
- `fault` output, 1 bit: sticky fault. Exists only with `MEM_FAULT_EN`.
- `fault_code` output, 2 bits: first fault cause. Exists only with `MEM_FAULT_EN`.

## Operation
- The FSM has three states: CLEAR, LOAD, RUN. `rst` forces CLEAR and clears the clear counter, the load pointer and the fault state.
- CLEAR writes `dmem[cnt]=0` and increments `cnt` each cycle. After writing `DMEM_DEPTH-1` the FSM moves to LOAD, so CLEAR lasts exactly `DMEM_DEPTH` cycles.
- LOAD:
  - `ld_ready=1`.
  - On `ld_valid&&ld_ready`, write `imem[ptr]=ld_data` and set `ptr++`.
  - Move to RUN after the accepted word that has `ld_last=1`, or after the word written at `ptr==IMEM_DEPTH-1`, whichever comes first. When both occur on the same word, take one transition.
  - Unloaded `imem` entries keep their old contents. `imem` is not cleared by `rst`.
- RUN:
  - `ld_ready=0`; `ld_valid` is ignored.
  - `d_we` high at a rising edge writes `dmem[d_addr[W+1:2]]=dw_data`, where W = log2(DMEM_DEPTH).
- Reads are combinational:
  - `ir_data=imem[i_addr[log2(IMEM_DEPTH)+1:2]]`. The result is the NOP `32'h0000_0013` when the address is out of range or the state is not RUN.
  - `dr_data=dmem[d_addr index]`. The result is 0 when the address is out of range.
  - Read-during-write to the same word returns the old value.
- Out-of-range means `addr>>2 >= depth`. Writes to out-of-range addresses are dropped.
- `d_we` is ignored outside RUN.

## Timing
- Reset values: `core_rst=1`, `ld_ready=0`. `fault=0` and `fault_code=0` (with the macro). `ir_data` is NOP.
- `core_rst` is registered as `state!=RUN`. It falls on the first edge on which the state is RUN: that is 1 cycle after the final load handshake, and `DMEM_DEPTH+N` cycles after `rst` falls for an N-word image loaded at full rate.
- `ld_ready` is combinational from the state and is high on every LOAD cycle. The loader may hold `ld_valid` low for any number of cycles without penalty.
- Read latency is 0 cycles; store latency is 1 edge.
- Asserting `rst` mid-LOAD or mid-RUN takes effect at the next edge:
  - `core_rst=1` the next cycle.
  - A partial image in `imem` is overwritten from index 0 on reload.
  - The clear restarts in full.

## Configuration
- `MEM_FAULT_EN` defined:
  - In RUN, a fault is any of: `i_addr[1:0]!=0` or `i_addr` out of range (code 1); `d_we` with `d_addr[1:0]!=0` (code 2); `d_we` with `d_addr` out of range (code 3).
  - `fault` sets and stays set until `rst`. `fault_code` latches the first cause only. When causes coincide, code 1 has priority over 2, which has priority over 3.
  - Misaligned stores are suppressed.
- `MEM_FAULT_EN` undefined: `fault` and `fault_code` do not exist, address bits [1:0] are ignored, and misaligned stores write the word they index.

## Structure
- Package `riscv_mem_pkg` holds:
  - the state enum (CLEAR/LOAD/RUN);
  - `NOP_INSN=32'h0000_0013`;
  - the fault-code constants.
- One sub-module, `riscv_word_ram`: a parameterized word array with async read and sync write, instantiated twice (imem, dmem).
- The FSM, counters and fault logic stay in the top module.

## Test plan
- Reset release with `DMEM_DEPTH=32`, loader idle → `core_rst=1` and `ld_ready=0` for 32 cycles, then `ld_ready=1`; every `dmem` word reads 0.
- Load 8 words back-to-back, `ld_last` on the 8th, with `ld_valid` dropped for 3 cycles mid-stream → `imem[0..7]` match; `core_rst` falls 1 cycle after the 8th handshake; `ir_data` at `i_addr=0x1C` equals the 8th word.
- Load `IMEM_DEPTH` words with no `ld_last` → transition to RUN after word 31; word 32 is not accepted (`ld_ready=0`).
- In RUN, drive `d_we=1`, `d_addr=0x10`, `dw_data=0xDEADBEEF` → `dr_data=0xDEADBEEF` from the next cycle. `i_addr=0x200` → `ir_data=0x00000013`.
- `MEM_FAULT_EN`: store to `d_addr=0x06` → no write, `fault=1`, `fault_code=2`. A later out-of-range store keeps `fault_code=2`.
- Assert `rst` mid-RUN → `core_rst=1` next cycle, 32-cycle clear repeats, and `dmem[4]` returns to 0.
